chargen_arbiter: RTL and testbench
==================================

CHARGEN_ARBITER -- requirements
Module: chargen_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, character-generator RAM address width (256 codes x 8 rows).
REQ-002 Parameter DATA_W, default 8, pixel-row data width.
REQ-003 Parameter RD_LAT, default 2, RAM read latency in cycles from address presentation to registered output.
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 vid_req  in  1  video fetch request, level; vid_code/vid_row held stable until vid_ack.
REQ-007 vid_code  in  8  character code.
REQ-008 vid_row  in  3  scanline within the glyph.
REQ-009 vid_ack  out  1  video request accepted this cycle.
REQ-010 vid_valid  out  1  one-cycle pulse; vid_data is valid.
REQ-011 vid_data  out  DATA_W  glyph row bits.
REQ-012 host_req  in  1  host (Z80/ESP font upload) request, level; fields held until host_ack.
REQ-013 host_we  in  1  1 = write, 0 = read.
REQ-014 host_addr  in  ADDR_W  RAM address.
REQ-015 host_wdata  in  DATA_W  write data.
REQ-016 host_ack  out  1  host request accepted this cycle.
REQ-017 host_rvalid  out  1  one-cycle pulse; host_rdata is valid.
REQ-018 host_rdata  out  DATA_W  read data.
REQ-019 ram_ce, ram_oce, ram_we  out  1 each  RAM port controls, registered.
REQ-020 ram_ad  out  ADDR_W  RAM address, registered; ram_din  out  DATA_W  write data, registered; ram_dout  in  DATA_W  RAM output.

Function
REQ-021 One RAM access per cycle at most; video has strict priority over host.
REQ-022 Video address = {vid_code, vid_row}.
REQ-023 vid_ack is asserted combinationally in any cycle with vid_req=1 and no reset.
REQ-024 host_ack is asserted only when vid_req=0, host_req=1, and the host FSM is H_IDLE.
REQ-025 Accepted request in cycle N drives ram_ce=1, ram_ad, ram_we, ram_din in cycle N+1; otherwise ram_ce=0 and ram_we=0.
REQ-026 A read accepted in cycle N returns data in cycle N+1+RD_LAT (N+3 at default) with exactly one valid pulse to the originating requester.
REQ-027 Source tags travel through an RD_LAT+1 deep shift register; the tag selects vid_valid or host_rvalid; both data outputs mirror ram_dout.
REQ-028 Back-to-back video reads every cycle are supported at full throughput, with return order equal to accept order.
REQ-029 Host FSM states: H_IDLE, H_RD_WAIT. A read ack moves H_IDLE to H_RD_WAIT. host_rvalid returns to H_IDLE. A write ack stays in H_IDLE and completes on the RAM in cycle N+1.
REQ-030 Only one outstanding host read is permitted; host_req while in H_RD_WAIT is not acked.
REQ-031 A host write followed by a video or host read of the same address returns the new data, because the accesses are serialized.
REQ-032 A host request pending while vid_req=1 waits indefinitely; its fields are not sampled until ack.
REQ-033 ram_oce is held at 1 whenever reset=0.

Reset
REQ-034 While reset=1: vid_ack, host_ack, vid_valid, host_rvalid, ram_ce, ram_we all 0; ram_ad and ram_din 0; ram_oce 0; vid_data and host_rdata 0.
REQ-035 Reset mid-operation clears the tag pipeline and returns the host FSM to H_IDLE; no valid pulses occur for reads accepted before reset.
REQ-036 Requests are acked from the first cycle after reset deasserts.

Structure
REQ-037 The tag encoding (TAG_NONE, TAG_VID, TAG_HOST), FSM state enum, and default parameter values live in the shared package chargen_pkg.
REQ-038 One sub-module, chargen_tag_pipe, implements the parameterized RD_LAT+1 tag shift register with synchronous clear.
REQ-039 The RAM instance sits outside this block.

Verification
REQ-040 Video-only: vid_req held 8 cycles with code 0x41, rows 0..7 -> eight vid_valid pulses starting 3 cycles after the first ack, data matching the RAM model, in order.
REQ-041 Contention: host read at 0x208 with vid_req=1 for 5 cycles -> no host_ack for 5 cycles; ack in cycle 6; host_rvalid 3 cycles later with the RAM contents.
REQ-042 Write-then-read: host write 0x5A to 0x7FF, then host read of 0x7FF -> host_rdata=0x5A; a video read of code 0xFF row 7 also returns 0x5A.
REQ-043 Outstanding limit: host read acked, host_req kept high -> no second host_ack until the cycle after host_rvalid.
REQ-044 Reset mid-flight: reset asserted 1 cycle after two video acks -> zero vid_valid pulses; all outputs 0 during reset; a normal ack follows reset release.
REQ-045 Assertions throughout: at most one ack per cycle, at most one valid per cycle, and valid count equals read-ack count for reads not cancelled by reset.

Source files
------------

// File: rtl/chargen_pkg.sv
// chargen_pkg -- shared definitions for the character-generator RAM arbiter.
//   * default parameter values (address width, data width, RAM read latency)
//   * source-tag encoding carried alongside each RAM access
//   * host FSM state encoding
//   * read_tag(): maps an accepted access to the tag it carries
package chargen_pkg;

  localparam int DEF_ADDR_W = 11;  // 256 codes x 8 rows
  localparam int DEF_DATA_W = 8;
  localparam int DEF_RD_LAT = 2;

  typedef logic [1:0] tag_t;

  localparam tag_t TAG_NONE = 2'd0;
  localparam tag_t TAG_VID  = 2'd1;
  localparam tag_t TAG_HOST = 2'd2;

  localparam logic [0:0] H_IDLE    = 1'b0;
  localparam logic [0:0] H_RD_WAIT = 1'b1;

  // Only reads produce a return, so writes travel as TAG_NONE.
  function automatic tag_t read_tag(input logic vid_acc, input logic host_rd_acc);
    if (vid_acc)          return TAG_VID;
    else if (host_rd_acc) return TAG_HOST;
    else                  return TAG_NONE;
  endfunction

endpackage

// File: rtl/chargen_tag_pipe.sv
// chargen_tag_pipe -- DEPTH-stage shift register of source tags.
// Ports:
//   clk      in   system clock
//   clear    in   synchronous clear (empties every stage)
//   tag_in   in   tag of the access issued this cycle
//   tag_out  out  tag emerging DEPTH cycles later
module chargen_tag_pipe
  import chargen_pkg::*;
#(
  parameter int DEPTH = DEF_RD_LAT + 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] tag_in,
  output logic [1:0] tag_out
);

  logic [2*DEPTH-1:0] shift_reg;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (clear) shift_reg <= TAG_NONE;
        else       shift_reg <= tag_in;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (clear) shift_reg <= '0;
        else       shift_reg <= {shift_reg[2*DEPTH-3:0], tag_in};
      end
    end
  endgenerate

  assign tag_out = shift_reg[2*DEPTH-1 -: 2];

endmodule

// File: rtl/chargen_arbiter.sv
// chargen_arbiter -- single-port arbiter for the character-generator RAM.
// Video fetches have strict priority; the host (font upload) gets the RAM
// only in cycles with no video request and may have one read outstanding.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   vid_req/vid_code/vid_row        video fetch request (address {code,row})
//   vid_ack/vid_valid/vid_data      video accept, return pulse, glyph row
//   host_req/host_we/host_addr/
//   host_wdata                      host read/write request
//   host_ack/host_rvalid/host_rdata host accept, read return pulse, data
//   ram_ce/ram_oce/ram_we/ram_ad/
//   ram_din/ram_dout                external RAM port (RD_LAT read latency)
module chargen_arbiter
  import chargen_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [7:0]        vid_code,
  input  logic [2:0]        vid_row,
  output logic              vid_ack,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [0:0]        h_state_reg, h_state_next;
  logic [ADDR_W-1:0] vid_addr;

  logic              ce_next, we_next;
  logic [ADDR_W-1:0] ad_next;
  logic [DATA_W-1:0] din_next;
  tag_t              tag_next;

  logic              ce_reg, we_reg;
  logic [ADDR_W-1:0] ad_reg;
  logic [DATA_W-1:0] din_reg;

  logic [1:0]        tag_out;
  logic              vid_ret, host_ret;

  assign vid_addr = ADDR_W'({vid_code, vid_row});

  // Arbitration: video wins outright; host needs an idle RAM slot and no
  // read already in flight.
  always_comb begin
    vid_ack  = vid_req & ~reset;
    host_ack = host_req & ~vid_req & ~reset & (h_state_reg == H_IDLE);

    ce_next  = 1'b0;
    we_next  = 1'b0;
    ad_next  = '0;
    din_next = '0;
    if (vid_ack) begin
      ce_next = 1'b1;
      ad_next = vid_addr;
    end else if (host_ack) begin
      ce_next  = 1'b1;
      we_next  = host_we;
      ad_next  = host_addr;
      din_next = host_wdata;
    end
    tag_next = read_tag(vid_ack, host_ack & ~host_we);
  end

  // Return decode straight from the tag pipe; masked by reset so nothing
  // can pulse in the first reset cycle before the pipe has been cleared.
  assign vid_ret  = (tag_out == TAG_VID)  & ~reset;
  assign host_ret = (tag_out == TAG_HOST) & ~reset;

  always_comb begin
    h_state_next = h_state_reg;
    case (h_state_reg)
      H_IDLE:    if (host_ack && !host_we) h_state_next = H_RD_WAIT;
      H_RD_WAIT: if (host_ret)             h_state_next = H_IDLE;
      default:                             h_state_next = H_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_state_reg <= H_IDLE;
      ce_reg      <= 1'b0;
      we_reg      <= 1'b0;
      ad_reg      <= '0;
      din_reg     <= '0;
    end else begin
      h_state_reg <= h_state_next;
      ce_reg      <= ce_next;
      we_reg      <= we_next;
      ad_reg      <= ad_next;
      din_reg     <= din_next;
    end
  end

  // Tag enters at the accept edge and emerges in the cycle the RAM output
  // register holds the data: 1 cycle to issue + RD_LAT cycles of RAM.
  chargen_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .clear   (reset),
    .tag_in  (tag_next),
    .tag_out (tag_out)
  );

  assign vid_valid   = vid_ret;
  assign host_rvalid = host_ret;
  assign vid_data    = reset ? '0 : ram_dout;
  assign host_rdata  = reset ? '0 : ram_dout;

  // RAM controls come from registers; the reset mask keeps the port idle
  // even in the first reset cycle, before the registers have cleared.
  assign ram_ce  = ce_reg & ~reset;
  assign ram_we  = we_reg & ~reset;
  assign ram_ad  = reset ? '0 : ad_reg;
  assign ram_din = reset ? '0 : din_reg;
  assign ram_oce = ~reset;

endmodule

// File: tb/tb_chargen_arbiter.sv
module tb_chargen_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              vid_req;
  logic [7:0]        vid_code;
  logic [2:0]        vid_row;
  logic              vid_ack, vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic              host_req, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack, host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              ram_ce, ram_oce, ram_we;
  logic [ADDR_W-1:0] ram_ad;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  always #5 clk = ~clk;

  chargen_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_code(vid_code), .vid_row(vid_row),
    .vid_ack(vid_ack), .vid_valid(vid_valid), .vid_data(vid_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_we(ram_we),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  function automatic logic [7:0] pattern(input int a);
    logic [10:0] aa;
    aa = a[10:0];
    return aa[7:0] ^ {aa[10:8], 5'b10101};
  endfunction

  // RAM model: RD_LAT-cycle registered read.
  logic [7:0] mem [2048];
  logic [7:0] rd_pipe [RD_LAT];
  logic       mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 2048; i++) mem[i] <= pattern(i);
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
      mem_init_done <= 1'b1;
    end else begin
      if (ram_ce && ram_we) mem[ram_ad] <= ram_din;
      if (ram_ce) rd_pipe[0] <= mem[ram_ad];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign ram_dout = mem_init_done ? rd_pipe[RD_LAT-1] : '0;

  // Scoreboard
  typedef struct {
    logic       is_host;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  logic [7:0] ref_mem [2048];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int vid_valid_cnt = 0, host_rvalid_cnt = 0;
  logic snap_vid_ack, snap_host_ack, snap_vid_valid, snap_host_rvalid;
  logic [7:0] last_vid_data, last_host_rdata;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  // One clock cycle: monitor/score at the falling edge, then advance.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    snap_vid_ack     = vid_ack;
    snap_host_ack    = host_ack;
    snap_vid_valid   = vid_valid;
    snap_host_rvalid = host_rvalid;
    chk("one_ack", {31'd0, vid_ack & host_ack}, 0);
    chk("one_valid", {31'd0, vid_valid & host_rvalid}, 0);
    if (reset) begin
      chk("rst_ctrl", {25'd0, vid_ack, host_ack, vid_valid, host_rvalid, ram_ce, ram_we, ram_oce}, 0);
      chk("rst_data", {8'd0, ram_din, vid_data, host_rdata}, 0);
      chk("rst_ad", {21'd0, ram_ad}, 0);
      sb.delete();
    end else begin
      chk("oce_high", {31'd0, ram_oce}, 1);
      if (vid_valid || host_rvalid) begin
        if (vid_valid) begin vid_valid_cnt++; last_vid_data = vid_data; end
        if (host_rvalid) begin host_rvalid_cnt++; last_host_rdata = host_rdata; end
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("ret_src", {31'd0, host_rvalid}, {31'd0, e.is_host});
          chk("ret_data", {24'd0, host_rvalid ? host_rdata : vid_data}, {24'd0, e.data});
          chk("ret_latency", cyc - e.cyc, RD_LAT + 1);
        end
      end
      if (vid_ack) begin
        e.is_host = 1'b0;
        e.data    = ref_mem[{vid_code, vid_row}];
        e.cyc     = cyc;
        sb.push_back(e);
      end else if (host_ack) begin
        if (host_we) begin
          ref_mem[host_addr] = host_wdata;
        end else begin
          e.is_host = 1'b1;
          e.data    = ref_mem[host_addr];
          e.cyc     = cyc;
          sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int vcnt0, hcnt0;

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = pattern(i);
    reset = 1'b1;
    vid_req = 1'b1; vid_code = 8'h12; vid_row = 3'd1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h010; host_wdata = 8'h00;

    // Reset: all outputs quiet even with requests pending.
    drain(4);
    vid_req = 1'b0; host_req = 1'b0;
    drain(1);

    // Video-only burst, code 0x41 rows 0..7, acked from first cycle out of reset.
    reset = 1'b0;
    vid_req = 1'b1; vid_code = 8'h41;
    for (int r = 0; r < 8; r++) begin
      vid_row = r[2:0];
      tick();
      chk("vid_burst_ack", {31'd0, snap_vid_ack}, 1);
    end
    vid_req = 1'b0;
    drain(6);
    chk("vid_burst_count", vid_valid_cnt, 8);

    // Contention: host read of 0x208 starved while video busy for 5 cycles.
    hcnt0 = host_rvalid_cnt;
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h208;
    vid_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vid_code = 8'h80 + k[7:0]; vid_row = k[2:0];
      tick();
      chk("contend_no_hack", {31'd0, snap_host_ack}, 0);
    end
    vid_req = 1'b0;
    tick();
    chk("contend_hack", {31'd0, snap_host_ack}, 1);
    host_req = 1'b0;
    drain(6);
    chk("contend_rvalid", host_rvalid_cnt - hcnt0, 1);
    chk("contend_rdata", {24'd0, last_host_rdata}, {24'd0, pattern(11'h208)});

    // Write 0x5A to 0x7FF, read it back by host and by video (code 0xFF row 7).
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h7FF; host_wdata = 8'h5A;
    tick();
    chk("wr_ack", {31'd0, snap_host_ack}, 1);
    host_we = 1'b0;
    tick();
    chk("rd_after_wr_ack", {31'd0, snap_host_ack}, 1);
    host_req = 1'b0;
    vid_req = 1'b1; vid_code = 8'hFF; vid_row = 3'd7;
    tick();
    vid_req = 1'b0;
    drain(5);
    chk("wr_rd_host", {24'd0, last_host_rdata}, 32'h5A);
    chk("wr_rd_vid", {24'd0, last_vid_data}, 32'h5A);

    // Outstanding limit: second host read only after the first returns.
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h123;
    tick();
    chk("out_first_ack", {31'd0, snap_host_ack}, 1);
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      tick();
      chk("out_blocked", {31'd0, snap_host_ack}, 0);
    end
    chk("out_rvalid_seen", {31'd0, snap_host_rvalid}, 1);
    tick();
    chk("out_second_ack", {31'd0, snap_host_ack}, 1);
    host_req = 1'b0;
    drain(5);

    // Reset mid-flight after two video acks: no returns for them.
    vcnt0 = vid_valid_cnt;
    vid_req = 1'b1; vid_code = 8'h33; vid_row = 3'd2;
    tick();
    vid_row = 3'd3;
    tick();
    vid_req = 1'b0; reset = 1'b1;
    drain(4);
    chk("rst_cancel", vid_valid_cnt - vcnt0, 0);
    reset = 1'b0;
    vid_req = 1'b1; vid_code = 8'h44; vid_row = 3'd5;
    tick();
    chk("post_rst_ack", {31'd0, snap_vid_ack}, 1);
    vid_req = 1'b0;
    drain(6);
    chk("post_rst_valid", vid_valid_cnt - vcnt0, 1);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
